// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution-window address generator.
package conv_pkg;

    localparam int DEF_DIM_W = 6;
    localparam int DEF_WIN   = 3;
    localparam int DEF_CH_W  = 4;
    localparam int DEF_STR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_DIM_W-1:0] win_r;
        logic [DEF_DIM_W-1:0] win_c;
        logic [3:0]           k_r;
        logic [3:0]           k_c;
        logic [DEF_CH_W-1:0]  ch;
    } point_t;

endpackage

// File: rtl/win_axis_cnt.sv
// Wrapping index counter; wrap is the carry into the next outer loop level.
module win_axis_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == limit) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_win_addr_gen.sv
// Walks every full WIN x WIN window of an H x W image per channel, one point per
// accepted handshake, for the line-buffer read port and MAC accumulate control.
module conv_win_addr_gen
    import conv_pkg::*;
#(
    parameter int DIM_W = DEF_DIM_W,
    parameter int WIN   = DEF_WIN,
    parameter int CH_W  = DEF_CH_W,
    parameter int STR_W = DEF_STR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_h,
    input  logic [DIM_W-1:0] cfg_w,
    input  logic [STR_W-1:0] cfg_stride,
    input  logic [CH_W-1:0]  cfg_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIM_W-1:0] win_r,
    output logic [DIM_W-1:0] win_c,
    output logic [3:0]       k_r,
    output logic [3:0]       k_c,
    output logic [DIM_W-1:0] pix_r,
    output logic [DIM_W-1:0] pix_c,
    output logic [CH_W-1:0]  ch,
    output logic             first_in_win,
    output logic             last_in_win,
    output logic             last_pt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int         AW    = DIM_W + STR_W + 1;
    localparam logic [3:0] K_MAX = 4'(WIN - 1);

    state_t             state;
    logic [DIM_W-1:0]   lat_h;
    logic [DIM_W-1:0]   lat_w;
    logic [STR_W-1:0]   lat_stride;
    logic [CH_W-1:0]    lat_ch;

    logic               xfer;
    logic               cfg_bad;
    logic               accept;
    logic               kc_wrap;
    logic               kr_wrap;
    logic               ch_wrap;
    logic               win_end;
    logic               fits_c;
    logic               fits_r;
    logic [AW-1:0]      step_c;
    logic [AW-1:0]      step_r;

    assign xfer    = out_valid && out_ready;
    assign cfg_bad = (cfg_h < DIM_W'(WIN)) || (cfg_w < DIM_W'(WIN)) ||
                     (cfg_stride == '0) || (cfg_ch == '0);
    assign accept  = (state == ST_IDLE) && start && !cfg_bad;

    // Widened so origin + stride + WIN can never wrap before the compare.
    assign step_c = AW'(win_c) + AW'(lat_stride);
    assign step_r = AW'(win_r) + AW'(lat_stride);
    assign fits_c = (step_c + AW'(WIN)) <= AW'(lat_w);
    assign fits_r = (step_r + AW'(WIN)) <= AW'(lat_h);

    win_axis_cnt #(.W(4)) u_kc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (xfer),
        .limit (K_MAX),
        .count (k_c),
        .wrap  (kc_wrap)
    );

    win_axis_cnt #(.W(4)) u_kr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (kc_wrap),
        .limit (K_MAX),
        .count (k_r),
        .wrap  (kr_wrap)
    );

    win_axis_cnt #(.W(CH_W)) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (kr_wrap),
        .limit (lat_ch - 1'b1),
        .count (ch),
        .wrap  (ch_wrap)
    );

    assign win_end      = (k_c == K_MAX) && (k_r == K_MAX) && (ch == lat_ch - 1'b1);
    assign first_in_win = out_valid && (k_c == '0) && (k_r == '0) && (ch == '0);
    assign last_in_win  = out_valid && win_end;
    assign last_pt      = last_in_win && !fits_c && !fits_r;
    assign pix_r        = win_r + DIM_W'(k_r);
    assign pix_c        = win_c + DIM_W'(k_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_h      <= '0;
            lat_w      <= '0;
            lat_stride <= '0;
            lat_ch     <= '0;
        end else if ((state == ST_IDLE) && start) begin
            lat_h      <= cfg_h;
            lat_w      <= cfg_w;
            lat_stride <= cfg_stride;
            lat_ch     <= cfg_ch;
        end
    end

    // Origin returns to 0 after the last window so outputs are clean on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r <= '0;
            win_c <= '0;
        end else if (accept) begin
            win_r <= '0;
            win_c <= '0;
        end else if (ch_wrap) begin
            if (fits_c) begin
                win_c <= step_c[DIM_W-1:0];
            end else begin
                win_c <= '0;
                win_r <= fits_r ? step_r[DIM_W-1:0] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            state     <= ST_RUN;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer && last_pt) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Directed bench for conv_win_addr_gen with a loop-nest reference model of the point stream.
module tb_conv_win_addr_gen;
    import conv_pkg::*;

    localparam int DIM_W = 6;
    localparam int WIN   = 3;
    localparam int CH_W  = 4;
    localparam int STR_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [DIM_W-1:0] cfg_h = '0;
    logic [DIM_W-1:0] cfg_w = '0;
    logic [STR_W-1:0] cfg_stride = '0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic             out_ready = 1'b1;
    logic             out_valid;
    logic [DIM_W-1:0] win_r, win_c, pix_r, pix_c;
    logic [3:0]       k_r, k_c;
    logic [CH_W-1:0]  ch;
    logic             first_in_win, last_in_win, last_pt, busy, done, err;
    logic [42:0]      all_out;

    conv_win_addr_gen #(.DIM_W(DIM_W), .WIN(WIN), .CH_W(CH_W), .STR_W(STR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_stride(cfg_stride), .cfg_ch(cfg_ch),
        .out_valid(out_valid), .out_ready(out_ready),
        .win_r(win_r), .win_c(win_c), .k_r(k_r), .k_c(k_c),
        .pix_r(pix_r), .pix_c(pix_c), .ch(ch),
        .first_in_win(first_in_win), .last_in_win(last_in_win), .last_pt(last_pt),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign all_out = {out_valid, win_r, win_c, k_r, k_c, pix_r, pix_c, ch,
                      first_in_win, last_in_win, last_pt, busy, done, err};

    int          n_checks = 0;
    int          n_pass = 0;
    point_t      exp_q[$];
    int          ppw = 1;
    int          idx = 0;
    bit          chk_en = 1'b0;
    bit          rand_ready = 1'b0;
    bit          done_due = 1'b0;
    int          first_pos[$];
    int          last_pos[$];
    logic [11:0] origins[$];
    logic [12:0] last_pix = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic build_model(input int h, input int w, input int s, input int c);
        point_t p;
        exp_q.delete();
        ppw = WIN * WIN * c;
        for (int r = 0; r + WIN <= h; r += s)
            for (int cc = 0; cc + WIN <= w; cc += s)
                for (int k = 0; k < c; k++)
                    for (int a = 0; a < WIN; a++)
                        for (int b = 0; b < WIN; b++) begin
                            p.win_r = 6'(r);
                            p.win_c = 6'(cc);
                            p.ch    = 4'(k);
                            p.k_r   = 4'(a);
                            p.k_c   = 4'(b);
                            exp_q.push_back(p);
                        end
    endtask

    // Compare process: every negedge while enabled, the presented point must match the model head.
    initial begin
        point_t      p;
        logic [39:0] act, expv;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                check("done_pulse", done, done_due);
                done_due = 1'b0;
                if (out_valid) begin
                    if (idx >= exp_q.size()) begin
                        check("extra_valid", 1, 0);
                    end else begin
                        p    = exp_q[idx];
                        act  = {win_r, win_c, k_r, k_c, pix_r, pix_c, ch,
                                first_in_win, last_in_win, last_pt, busy};
                        expv = {p.win_r, p.win_c, p.k_r, p.k_c,
                                6'(p.win_r + p.k_r), 6'(p.win_c + p.k_c), p.ch,
                                (idx % ppw) == 0, (idx % ppw) == ppw - 1,
                                idx == exp_q.size() - 1, 1'b1};
                        check($sformatf("point_%0d", idx + 1), act, expv);
                        if (out_ready) begin
                            if (first_in_win) begin
                                first_pos.push_back(idx + 1);
                                origins.push_back({win_r, win_c});
                            end
                            if (last_in_win) last_pos.push_back(idx + 1);
                            if (idx == exp_q.size() - 1) begin
                                done_due = 1'b1;
                                last_pix = {pix_r, pix_c, last_pt};
                            end
                            idx++;
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_start(input int h, input int w, input int s, input int c);
        @(negedge clk);
        cfg_h = 6'(h); cfg_w = 6'(w); cfg_stride = 4'(s); cfg_ch = 4'(c);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic arm_model(input int h, input int w, input int s, input int c,
                             input bit rnd, input int expect_n);
        build_model(h, w, s, c);
        check("model_size", exp_q.size(), expect_n);
        idx = 0;
        done_due = 1'b0;
        first_pos.delete();
        last_pos.delete();
        origins.delete();
        rand_ready = rnd;
        chk_en = 1'b1;
    endtask

    task automatic run_case(input int h, input int w, input int s, input int c,
                            input bit rnd, input int expect_n);
        int cyc;
        arm_model(h, w, s, c, rnd, expect_n);
        pulse_start(h, w, s, c);
        cyc = 0;
        while (idx < expect_n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("xfer_count", idx, expect_n);
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        out_ready = 1'b1;
        #1;
        check("idle_after_run", {busy, out_valid, done}, 3'b000);
    endtask

    task automatic bad_cfg(input int h, input int w, input int s, input int c, input string nm);
        pulse_start(h, w, s, c);
        @(negedge clk);
        check({nm, "_err"}, {err, busy, out_valid}, 3'b100);
        @(negedge clk);
        check({nm, "_after"}, {err, busy, out_valid}, 3'b000);
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        check("reset_state", all_out, 43'd0);
        rst_n = 1'b1;

        // 6x6, stride 3, one channel
        run_case(6, 6, 3, 1, 1'b0, 36);
        check("model_pt10", {exp_q[9].win_r, exp_q[9].win_c, exp_q[9].k_r, exp_q[9].k_c}, {6'd0, 6'd3, 4'd0, 4'd0});
        check("6x6_n_windows", origins.size(), 4);
        if (origins.size() == 4)
            check("6x6_origins", {origins[0], origins[1], origins[2], origins[3]},
                  {6'd0, 6'd0, 6'd0, 6'd3, 6'd3, 6'd0, 6'd3, 6'd3});
        check("6x6_last_pix", last_pix, {6'd5, 6'd5, 1'b1});

        // 5 rows x 4 columns, stride 2: only column origin 0 fits
        run_case(5, 4, 2, 1, 1'b0, 18);
        check("5x4_n_windows", origins.size(), 2);
        if (origins.size() == 2)
            check("5x4_origins", {origins[0], origins[1]}, {6'd0, 6'd0, 6'd2, 6'd0});

        // 4x4, stride 1, two channels
        run_case(4, 4, 1, 2, 1'b0, 72);
        check("model_ch_pt10", exp_q[9].ch, 1);
        check("4x4_first_cnt", first_pos.size(), 4);
        if (first_pos.size() == 4)
            check("4x4_first_pos", {8'(first_pos[0]), 8'(first_pos[1]), 8'(first_pos[2]), 8'(first_pos[3])},
                  {8'd1, 8'd19, 8'd37, 8'd55});
        check("4x4_last_cnt", last_pos.size(), 4);
        if (last_pos.size() == 4)
            check("4x4_last_pos", {8'(last_pos[0]), 8'(last_pos[1]), 8'(last_pos[2]), 8'(last_pos[3])},
                  {8'd18, 8'd36, 8'd54, 8'd72});

        // 6x6 with random back-pressure
        run_case(6, 6, 3, 1, 1'b1, 36);
        check("stall_last_pix", last_pix, {6'd5, 6'd5, 1'b1});

        bad_cfg(2, 6, 3, 1, "small_h");
        bad_cfg(6, 6, 0, 1, "zero_stride");
        bad_cfg(6, 6, 3, 0, "zero_ch");

        // Abort mid-run with reset around transfer 10
        arm_model(6, 6, 3, 1, 1'b0, 36);
        pulse_start(6, 6, 3, 1);
        cyc = 0;
        while (idx < 9 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached", idx >= 9, 1);
        @(posedge clk);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", all_out, 43'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {done, busy, out_valid}, 3'b000);
        end
        rst_n = 1'b1;
        run_case(6, 6, 3, 1, 1'b0, 36);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
